// File: rtl/seq_multiplier.sv
// Sequential RV32M multiplier: one shift-add step per cycle over a 64-bit accumulator.
// Signed operands are reduced to magnitudes up front and the product sign is restored in DONE.
module seq_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] FN_MUL    = 2'b00;
    localparam logic [1:0] FN_MULH   = 2'b01;
    localparam logic [1:0] FN_MULHSU = 2'b10;

    localparam logic [4:0] LAST_STEP = 5'd31;

    logic [1:0]  state_r;
    logic [63:0] acc_r;
    logic [31:0] mcand_r;
    logic [1:0]  funct_r;
    logic        sign_r;
    logic [4:0]  count_r;
    logic [31:0] result_r;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [32:0] sum_s;
    logic [63:0] acc_step_s;
    logic [63:0] product_s;
    logic [31:0] word_s;
    logic        done_s;

    function automatic logic [32:0] ripple_add(input logic [31:0] x, input logic [31:0] y);
        logic        c;
        logic [32:0] s;
        c = 1'b0;
        s = 33'd0;
        for (int i = 0; i < 32; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        s[32] = c;
        return s;
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] negate64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Operand sign decode for the capture edge
    always_comb begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
        case (funct)
            FN_MULH: begin
                a_neg_s = op_a[31];
                b_neg_s = op_b[31];
            end
            FN_MULHSU: begin
                a_neg_s = op_a[31];
                b_neg_s = 1'b0;
            end
            default: begin
                a_neg_s = 1'b0;
                b_neg_s = 1'b0;
            end
        endcase
    end

    // One shift-add step; the 33rd sum bit shifts back into bit 63
    always_comb begin
        sum_s = ripple_add(acc_r[63:32], mcand_r);
        if (acc_r[0]) begin
            acc_step_s = {sum_s, acc_r[31:1]};
        end else begin
            acc_step_s = {1'b0, acc_r[63:1]};
        end
    end

    // Sign restoration and word select for the completing operation
    always_comb begin
        if (sign_r) begin
            product_s = negate64(acc_r);
        end else begin
            product_s = acc_r;
        end
        if (funct_r == FN_MUL) begin
            word_s = product_s[31:0];
        end else begin
            word_s = product_s[63:32];
        end
    end

    // Output decode: a flush or reset during DONE suppresses the pulse in that same cycle
    always_comb begin
        done_s = (state_r == ST_DONE) && !flush && !rst;
        busy   = (state_r != ST_IDLE);
        valid  = done_s;
        if (done_s) begin
            result = word_s;
        end else begin
            result = result_r;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            acc_r    <= 64'd0;
            mcand_r  <= 32'd0;
            funct_r  <= 2'b00;
            sign_r   <= 1'b0;
            count_r  <= 5'd0;
            result_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        mcand_r <= magnitude(op_a, a_neg_s);
                        acc_r   <= {32'd0, magnitude(op_b, b_neg_s)};
                        funct_r <= funct;
                        sign_r  <= a_neg_s ^ b_neg_s;
                        count_r <= 5'd0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                    end else begin
                        acc_r   <= acc_step_s;
                        count_r <= count_r + 5'd1;
                        if (count_r == LAST_STEP) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        result_r <= word_s;
                    end else begin
                        result_r <= result_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed table, random ops against a 64-bit arithmetic model,
// and hand-written flush / reset / ignored-start sequences.
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [1:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int errors;
    int checks;
    int valid_count;

    seq_multiplier dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct  (funct),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_count++;
    end

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    // Reference: full 64-bit product of the operands extended per RV32M signedness
    function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        if (f == 2'b01 || f == 2'b10) sa = longint'($signed(a));
        else                          sa = longint'({32'd0, a});
        if (f == 2'b01) sb = longint'($signed(b));
        else            sb = longint'({32'd0, b});
        p = 64'(sa * sb);
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for valid, check latency and busy profile
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] got);
        int   n;
        logic busy_ok;
        funct = f; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        funct = 2'($urandom); op_a = $urandom; op_b = $urandom;
        n = 0;
        busy_ok = 1'b1;
        while (valid !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd32);
        check("busy_run", 32'(busy_ok), 32'd1);
        check("busy_done", 32'(busy), 32'd1);
        got = result;
        tick();
        check("busy_idle", 32'(busy), 32'd0);
        check("valid_one_cycle", 32'(valid), 32'd0);
    endtask

    vec_t        vecs[10];
    logic [31:0] got;
    logic [31:0] prior;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rf;
    int          vc0;
    int          n;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0; checks = 0; valid_count = 0;
        vecs[0] = '{2'b00, 32'd7,          32'd6,          32'h0000_002A};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
        vecs[3] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[4] = '{2'b10, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
        vecs[5] = '{2'b01, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[6] = '{2'b00, 32'h1234_5678,  32'd0,          32'h0000_0000};
        vecs[7] = '{2'b11, 32'h8000_0000,  32'd2,          32'h0000_0001};
        vecs[8] = '{2'b01, 32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF};
        vecs[9] = '{2'b10, 32'd2,          32'hFFFF_FFFF,  32'h0000_0001};

        // Reset with start/flush held: everything idle and zero
        rst = 1'b1; start = 1'b1; flush = 1'b1; funct = 2'b00; op_a = 32'd5; op_b = 32'd5;
        tick(); tick(); tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        tick();
        check("reset_release_idle", 32'(busy), 32'd0);

        // Directed table, issued back-to-back
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, got);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
            check($sformatf("vec%0d_hold", i), result, vecs[i].exp);
        end
        prior = vecs[9].exp;

        // Start pulses during RUN are ignored
        vc0 = valid_count;
        funct = 2'b00; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        tick();
        n = 0;
        for (int k = 1; k <= 40 && valid !== 1'b1; k++) begin
            start = (k == 5 || k == 15);
            funct = 2'b11; op_a = $urandom; op_b = $urandom;
            tick();
            n = k;
        end
        start = 1'b0;
        check("ignored_start_latency", 32'(n), 32'd32);
        check("ignored_start_result", result, model(2'b00, 32'd1234, 32'd5678));
        tick(); tick(); tick();
        check("ignored_start_busy", 32'(busy), 32'd0);
        check("ignored_start_one_valid", 32'(valid_count - vc0), 32'd1);
        prior = model(2'b00, 32'd1234, 32'd5678);

        // Flush at RUN cycle 10
        vc0 = valid_count;
        funct = 2'b11; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_run_busy", 32'(busy), 32'd0);
        check("flush_run_valid", 32'(valid), 32'd0);
        check("flush_run_result", result, prior);
        repeat (35) tick();
        check("flush_run_no_valid", 32'(valid_count - vc0), 32'd0);
        run_op(2'b00, 32'd100, 32'd300, got);
        check("after_flush_result", got, 32'd30000);
        prior = 32'd30000;

        // Flush in DONE suppresses the pulse and keeps the old result
        vc0 = valid_count;
        funct = 2'b01; op_a = 32'h7FFF_FFFF; op_b = 32'h7FFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        check("done_reached", 32'(valid), 32'd1);
        flush = 1'b1;
        #1;
        check("flush_done_valid", 32'(valid), 32'd0);
        check("flush_done_result", result, prior);
        tick();
        flush = 1'b0;
        check("flush_done_busy", 32'(busy), 32'd0);
        check("flush_done_hold", result, prior);
        check("flush_done_no_valid", 32'(valid_count - vc0), 32'd0);

        // Flush wins over start in IDLE
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", 32'(busy), 32'd0);
        tick();
        check("flush_start_idle2", 32'(busy), 32'd0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, got);
            check($sformatf("rand%0d f=%0d a=%h b=%h", i, rf, ra, rb), got, model(rf, ra, rb));
        end

        // Reset at RUN cycle 20, with start and flush also high
        vc0 = valid_count;
        funct = 2'b00; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1; start = 1'b1; flush = 1'b1;
        tick();
        check("rst_run_busy", 32'(busy), 32'd0);
        check("rst_run_valid", 32'(valid), 32'd0);
        check("rst_run_result", result, 32'd0);
        rst = 1'b0; start = 1'b0; flush = 1'b0;
        repeat (40) tick();
        check("rst_run_idle", 32'(busy), 32'd0);
        check("rst_run_no_valid", 32'(valid_count - vc0), 32'd0);
        run_op(2'b00, 32'd7, 32'd6, got);
        check("after_rst_result", got, 32'h0000_002A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-003: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-004: flush  input  1  pipeline kill; aborts any operation in progress.
REQ-005: funct  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M encoding).
REQ-006: op_a  input  32  multiplicand (rs1); captured when start is accepted.
REQ-007: op_b  input  32  multiplier (rs2); captured when start is accepted.
REQ-008: busy  output  1  high while state is not IDLE.
REQ-009: valid  output  1  one-cycle pulse; result is valid.
REQ-010: result  output  32  product low word (MUL) or high word (MULH/MULHSU/MULHU).

Function
REQ-011: FSM states IDLE, RUN, DONE; datapath is one 64-bit accumulator (upper half plus multiplier-shift lower half), a 32-bit ripple add of the shifted multiplicand, and a 5-bit step counter.
REQ-012: IDLE, start=1, flush=0 -> capture operand magnitudes, funct and result-sign flag; clear accumulator; counter=0; go to RUN.
REQ-013: Operand signedness: op_a signed for MULH and MULHSU; op_b signed for MULH only; a signed negative operand is replaced by its two's-complement magnitude.
REQ-014: Result sign flag = XOR of the signs of the operands treated as signed; 0 for MUL-low-only semantics is not special-cased (the 64-bit product is negated when flag=1).
REQ-015: RUN: each cycle, if accumulator bit 0 = 1, add multiplicand to the upper 32 bits with 33-bit carry; shift the whole accumulator right 1 with carry into bit 63; counter increments.
REQ-016: RUN exits to DONE after exactly 32 RUN cycles (counter wraps 31 -> 0 on the transition).
REQ-017: DONE: 64-bit product negated if sign flag set; result = low word for MUL, else high word; valid=1 for this cycle only; next state IDLE.
REQ-018: Latency: start accepted at edge t -> valid high in cycle t+33; busy high from t+1 through t+33 inclusive.
REQ-019: result holds its last value after DONE until the next DONE; it is not cleared on start.
REQ-020: start while busy=1 is ignored (no queuing, no effect on running operation).
REQ-021: flush=1 in RUN or DONE -> next state IDLE, valid=0 in that cycle and after, result unchanged from previous completed op.
REQ-022: flush=1 with start=1 in IDLE -> flush wins; stay IDLE.
REQ-023: Back-to-back: start may be asserted in the cycle after DONE (IDLE); no dead cycle beyond that.
REQ-024: Operand inputs are don't-care except at the accepting edge.

Reset
REQ-025: rst=1 at a rising edge -> state IDLE, busy=0, valid=0, result=32'h0, counter=0, accumulator=0; overrides start and flush.
REQ-026: rst asserted mid-RUN or in DONE -> no valid pulse for the aborted operation.

Verification
REQ-027: MUL, op_a=7, op_b=6, start at edge 0 -> valid at cycle 33, result=32'h0000002A, busy low at cycle 34.
REQ-028: MULH, op_a=op_b=32'hFFFFFFFF -> result=32'h00000000; same operands with MUL -> result=32'h00000001.
REQ-029: MULHU, op_a=op_b=32'hFFFFFFFF -> result=32'hFFFFFFFE; MULHSU op_a=32'hFFFFFFFF, op_b=2 -> result=32'hFFFFFFFF.
REQ-030: start pulses during RUN with different operands -> ignored; original result delivered at cycle 33, exactly one valid.
REQ-031: flush at RUN cycle 10 -> busy=0 next cycle, no valid, result retains prior value; new start then completes normally in 33 cycles.
REQ-032: rst asserted at RUN cycle 20 -> all outputs zero next cycle, no valid; start/flush together with rst have no effect.
